// File: rtl/bcd_display_prep.sv
// bcd_display_prep: turns a binary request into 8 packed display nibbles
// (raw hex or iterative double-dabble decimal) plus a leading-zero-blanked
// per-digit valid mask for the seven-segment scanner.
module bcd_display_prep #(
  parameter int IN_W    = 32,
  parameter int DEC_MAX = 99999999
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IN_W-1:0] in_value,
  input  logic            in_hex,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [31:0]     output_data,
  output logic [7:0]      output_valid,
  output logic            overflow,
  output logic            done
);

  typedef enum logic [1:0] {IDLE, CONVERT, FINISH} state_t;

  localparam int          CNT_W       = $clog2(IN_W + 1);
  localparam logic [63:0] DEC_MAX_EXT = 64'(DEC_MAX);
  localparam logic [31:0] SAT_DIGITS  = 32'h9999_9999;

  state_t            state_q, state_d;
  logic [IN_W-1:0]   bin_q, bin_d;
  logic [31:0]       bcd_q, bcd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sat_q, sat_d;
  logic [31:0]       data_q, data_d;
  logic [7:0]        valid_q, valid_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;

  logic [63:0]       in_ext;
  logic              in_too_big;
  logic [31:0]       adj;
  logic [7:0]        mask;
  logic              unused_adj_msb;

  // Widen the request once so the saturation compare and hex pass-through
  // work for any IN_W up to 64.
  assign in_ext     = 64'(in_value);
  assign in_too_big = (in_ext > DEC_MAX_EXT);

  // Double-dabble pre-shift correction: any digit >= 5 gets +3 so the
  // following left shift carries correctly into the next decimal digit.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_adj
      assign adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ?
                              (bcd_q[4*gi +: 4] + 4'd3) : bcd_q[4*gi +: 4];
    end
  endgenerate

  // The top adjusted bit is shifted out; legal values never set it.
  assign unused_adj_msb = adj[31];

  // Leading-zero blanking: digit k shows if it or any higher digit is
  // nonzero; digit 0 always shows.
  generate
    for (gi = 0; gi < 8; gi++) begin : g_mask
      if (gi == 0) begin : g_lsd
        assign mask[gi] = 1'b1;
      end else begin : g_upper
        assign mask[gi] = |bcd_q[31:4*gi];
      end
    end
  endgenerate

  assign in_ready     = (state_q == IDLE);
  assign output_data  = data_q;
  assign output_valid = valid_q;
  assign overflow     = ovf_q;
  assign done         = done_q;

  // Next-state and datapath: accept, iterate, then publish in FINISH.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_hex) begin
            bcd_d   = in_ext[31:0];
            sat_d   = 1'b0;
            state_d = FINISH;
          end else if (in_too_big) begin
            bcd_d   = SAT_DIGITS;
            sat_d   = 1'b1;
            state_d = FINISH;
          end else begin
            bin_d   = in_value;
            bcd_d   = '0;
            cnt_d   = '0;
            sat_d   = 1'b0;
            state_d = CONVERT;
          end
        end
      end
      CONVERT: begin
        bcd_d = {adj[30:0], bin_q[IN_W-1]};
        bin_d = bin_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(IN_W - 1)) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        data_d  = bcd_q;
        valid_d = mask;
        ovf_d   = sat_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 8'h01;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: doc/bcd_display_prep.md
Name: bcd_display_prep

Overview:
- Upstream feeder for the 8-digit seven-segment scanner.
- Accepts a binary value through a valid/ready handshake and converts it to 8 packed hex or BCD nibbles with iterative double-dabble.
- Produces a per-digit valid mask with leading-zero blanking.
- Drives the scanner's output_data[31:0] and output_valid[7:0] directly; both hold stable between updates.

Parameters:
- IN_W, 32, input value width; also the number of double-dabble iterations.
- DEC_MAX, 99999999, largest value displayable in decimal mode; larger values saturate.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- in_value  input  IN_W  binary value to display
- in_hex  input  1  1 = show raw hex nibbles, 0 = show decimal
- in_valid  input  1  request strobe; sampled when in_ready=1
- in_ready  output  1  high iff state=IDLE (combinational from state)
- output_data  output  32  packed digits to the scanner, digit k in bits [4k+3:4k]
- output_valid  output  8  per-digit enable to the scanner
- overflow  output  1  last decimal request exceeded DEC_MAX
- done  output  1  one-cycle pulse, high in the first cycle new output_data is visible

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, output_data=0, output_valid=8'h01, overflow=0, done=0, internal shift/BCD registers=0.
  - Reset mid-conversion aborts the conversion; no done is produced for the aborted request.
- Accept: at the clock edge where in_valid && in_ready, latch in_value and in_hex. This edge is T.
  - in_valid while in_ready=0 is ignored (no queueing, no error).
- State machine IDLE / CONVERT / FINISH:
  - IDLE -> FINISH on accept when in_hex=1; result = in_value[31:0].
  - IDLE -> FINISH on accept when in_hex=0 and in_value > DEC_MAX; result = 32'h99999999, overflow pending.
  - IDLE -> CONVERT on accept when in_hex=0 and in_value <= DEC_MAX; iteration counter cleared, BCD register=0.
  - CONVERT: one iteration per edge, IN_W iterations total (edges T+1..T+IN_W).
    - Each iteration: every BCD nibble >= 5 gets +3 (combinational), then {bcd, bin} shifts left 1.
    - The bin MSB enters the bcd LSB.
    - The 4-bit adds discard carry-out of the nibble (cannot occur for legal values).
    - After the last iteration -> FINISH.
  - FINISH (one cycle) -> IDLE. At this edge the block registers output_data, output_valid and overflow, and asserts done.
- Latency:
  - Hex or saturated request: outputs update at edge T+1; done high for the cycle after T+1.
  - Decimal request: outputs update at edge T+IN_W+1 (T+33 by default).
  - in_ready returns high in the same cycle done is high, so back-to-back accept is allowed on that cycle.
- Valid mask:
  - output_valid[k] = 1 iff some digit j >= k is nonzero, or k = 0.
  - Digit 0 is always shown; zero value gives 8'h01.
  - Applies identically in hex and decimal modes.
- overflow:
  - Set to 1 only by a saturated decimal request.
  - Cleared by any other completed request.
  - Holds its value between requests.
- Outputs change only at FINISH edges or reset; never glitch mid-conversion.

Test Plan:
1. Decimal 12345 -> in_ready low for 33 cycles. At edge T+33: output_data=32'h00012345, output_valid=8'h1F, overflow=0, done pulses once.
2. Decimal 0 -> output_data=0, output_valid=8'h01. Then decimal 99999999 -> 32'h99999999, 8'hFF, overflow=0.
3. Decimal 100000000 -> at edge T+1: output_data=32'h99999999, output_valid=8'hFF, overflow=1. A following hex 5 clears overflow and gives data 5, valid 8'h01.
4. Hex 32'h00A0B00C -> output_data=32'h00A0B00C, output_valid=8'h3F, done one cycle after accept.
5. in_valid held high with changing in_value during a decimal conversion:
   - Only the first value is converted.
   - The second accept occurs exactly on the done cycle.
   - Outputs are stable throughout the conversion.
6. rst pulsed at T+10 of a conversion -> immediately output_data=0, output_valid=8'h01, overflow=0, in_ready=1; no done; the next request converts correctly.
